axi_rd_arbiter: RTL and testbench

//  Shares the single CPU AXI read port (AR/R) between the instruction-fetch and data-load request channels.

---
 rtl/axi_rd_arbiter_pkg.sv | 21 ++
 rtl/axi_rd_arbiter_if.sv | 46 ++++
 rtl/rd_arb_sel.sv | 35 +++
 rtl/axi_rd_arbiter.sv | 90 +++++++++
 tb/tb_axi_rd_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared encodings for the CPU AXI read-port arbiter: FSM states, requester owner and
// the fixed single-beat AXI read attributes.
package axi_rd_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AR   = 2'd1,
      ST_R    = 2'd2,
      ST_RESP = 2'd3
   } state_e;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } owner_e;

   localparam logic [2:0] ARSIZE_4B    = 3'b010;
   localparam logic [1:0] ARBURST_INCR = 2'b01;
   localparam logic [7:0] ARLEN_SINGLE = 8'd0;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Bundle of the core-side fetch/load channels and the AXI AR/R port around the read arbiter.
// master = arbiter side, slave = core plus interconnect side.
interface axi_rd_arbiter_if #(
   parameter int ADDR_W     = 32,
   parameter int AXI_ADDR_W = 40,
   parameter int DATA_W     = 32
);
   logic [ADDR_W-1:0]     PC;
   logic                  Inst_Req_Valid;
   logic                  Inst_Req_Ready;
   logic [DATA_W-1:0]     Instruction;
   logic                  Inst_Valid;
   logic                  Inst_Ready;
   logic [ADDR_W-1:0]     Address;
   logic                  MemRead;
   logic                  Mem_Req_Ready;
   logic [DATA_W-1:0]     Read_data;
   logic                  Read_data_Valid;
   logic                  Read_data_Ready;
   logic [AXI_ADDR_W-1:0] cpu_araddr;
   logic                  cpu_arvalid;
   logic                  cpu_arready;
   logic [2:0]            cpu_arsize;
   logic [1:0]            cpu_arburst;
   logic [7:0]            cpu_arlen;
   logic [DATA_W-1:0]     cpu_rdata;
   logic                  cpu_rvalid;
   logic                  cpu_rready;
   logic                  cpu_rlast;

   modport master (
      input  PC, Inst_Req_Valid, Inst_Ready, Address, MemRead, Read_data_Ready,
             cpu_arready, cpu_rdata, cpu_rvalid, cpu_rlast,
      output Inst_Req_Ready, Instruction, Inst_Valid, Mem_Req_Ready, Read_data,
             Read_data_Valid, cpu_araddr, cpu_arvalid, cpu_arsize, cpu_arburst,
             cpu_arlen, cpu_rready
   );

   modport slave (
      output PC, Inst_Req_Valid, Inst_Ready, Address, MemRead, Read_data_Ready,
             cpu_arready, cpu_rdata, cpu_rvalid, cpu_rlast,
      input  Inst_Req_Ready, Instruction, Inst_Valid, Mem_Req_Ready, Read_data,
             Read_data_Valid, cpu_araddr, cpu_arvalid, cpu_arsize, cpu_arburst,
             cpu_arlen, cpu_rready
   );
endinterface

// File: rtl/rd_arb_sel.sv
// Grant selection between fetch and load requests. Fixed load priority by default;
// round-robin on ties with the last_grant register when RD_ARB_RR_EN is defined.
module rd_arb_sel
   import axi_rd_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic inst_vld,
   input  logic data_vld,
   input  logic grant_fire,
   output logic gnt_inst,
   output logic gnt_data
);

`ifdef RD_ARB_RR_EN
   owner_e last_grant_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_grant_q <= OWN_INST;
      else if (grant_fire)
         last_grant_q <= gnt_data ? OWN_DATA : OWN_INST;
   end

   // Reset value INST makes the first tie go to the load channel.
   assign gnt_data = data_vld && (!inst_vld || last_grant_q == OWN_INST);
`else
   logic unused_rr;
   assign unused_rr = ^{clk, rst_n, grant_fire};
   assign gnt_data  = data_vld;
`endif

   assign gnt_inst = inst_vld && !gnt_data;

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares the CPU AXI read port between instruction fetch and data load, one single-beat
// transaction outstanding. Round-robin tie-break is enabled by defining RD_ARB_RR_EN.
module axi_rd_arbiter
   import axi_rd_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int AXI_ADDR_W = 40,
   parameter int DATA_W     = 32
) (
   input  logic              cpu_clk,
   input  logic              cpu_resetn,
   axi_rd_arbiter_if.master  bus
);

   state_e            state_q, state_d;
   owner_e            owner_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              gnt_inst, gnt_data;
   logic              req_fire;
   logic              resp_ready;

   rd_arb_sel u_sel (
      .clk        (cpu_clk),
      .rst_n      (cpu_resetn),
      .inst_vld   (bus.Inst_Req_Valid),
      .data_vld   (bus.MemRead),
      .grant_fire (req_fire),
      .gnt_inst   (gnt_inst),
      .gnt_data   (gnt_data)
   );

   assign req_fire   = cpu_resetn && (state_q == ST_IDLE) && (gnt_inst || gnt_data);
   assign resp_ready = (owner_q == OWN_DATA) ? bus.Read_data_Ready : bus.Inst_Ready;

   always_ff @(posedge cpu_clk or negedge cpu_resetn) begin
      if (!cpu_resetn)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (req_fire)                           state_d = ST_AR;
         ST_AR:   if (bus.cpu_arready)                    state_d = ST_R;
         ST_R:    if (bus.cpu_rvalid && bus.cpu_rlast)    state_d = ST_RESP;
         ST_RESP: if (resp_ready)                         state_d = ST_IDLE;
         default:                                         state_d = ST_IDLE;
      endcase
   end

   // Request address/owner captured at grant; read beat captured while in R.
   always_ff @(posedge cpu_clk or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         owner_q <= OWN_INST;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         if (req_fire) begin
            owner_q <= gnt_data ? OWN_DATA : OWN_INST;
            addr_q  <= gnt_data ? bus.Address : bus.PC;
         end
         if (state_q == ST_R && bus.cpu_rvalid)
            data_q <= bus.cpu_rdata;
      end
   end

   always_comb begin
      bus.Inst_Req_Ready  = 1'b0;
      bus.Mem_Req_Ready   = 1'b0;
      if (cpu_resetn && state_q == ST_IDLE) begin
         bus.Inst_Req_Ready = gnt_inst;
         bus.Mem_Req_Ready  = gnt_data;
      end
      bus.cpu_arvalid     = (state_q == ST_AR);
      bus.cpu_rready      = (state_q == ST_R);
      bus.Inst_Valid      = (state_q == ST_RESP) && (owner_q == OWN_INST);
      bus.Read_data_Valid = (state_q == ST_RESP) && (owner_q == OWN_DATA);
   end

   assign bus.cpu_araddr  = {{(AXI_ADDR_W-ADDR_W){1'b0}}, addr_q};
   assign bus.cpu_arsize  = ARSIZE_4B;
   assign bus.cpu_arburst = ARBURST_INCR;
   assign bus.cpu_arlen   = ARLEN_SINGLE;
   assign bus.Instruction = data_q;
   assign bus.Read_data   = data_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: vector table of single transactions plus hand-written
// tie, reset and idle sequences. Expected tie order follows RD_ARB_RR_EN when defined.
module tb_axi_rd_arbiter;

`ifdef RD_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic cpu_clk;
   logic cpu_resetn;
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   int   ar_cnt = 0;

   axi_rd_arbiter_if bus ();

   axi_rd_arbiter dut (
      .cpu_clk    (cpu_clk),
      .cpu_resetn (cpu_resetn),
      .bus        (bus)
   );

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   always @(posedge cpu_clk) begin
      cyc <= cyc + 1;
      if (cpu_resetn && bus.cpu_arvalid && bus.cpu_arready)
         ar_cnt <= ar_cnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      bit          iv;
      logic [31:0] pc;
      bit          dv;
      logic [31:0] ad;
      int          ar_dly;
      int          r_dly;
      logic [31:0] rd;
      int          stall;
      bit          pend;
      bit          exp_data;
      logic [39:0] exp_addr;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.PC = '0; bus.Inst_Req_Valid = 1'b0; bus.Inst_Ready = 1'b0;
      bus.Address = '0; bus.MemRead = 1'b0; bus.Read_data_Ready = 1'b0;
      bus.cpu_arready = 1'b0; bus.cpu_rdata = '0; bus.cpu_rvalid = 1'b0; bus.cpu_rlast = 1'b0;
   endtask

   function automatic bit busy_ok();
      return !bus.Inst_Req_Ready && !bus.Mem_Req_Ready;
   endfunction

   task automatic do_reset();
      @(negedge cpu_clk);
      clear_inputs();
      cpu_resetn = 1'b0;
      @(negedge cpu_clk);
      cpu_resetn = 1'b1;
      @(posedge cpu_clk); #1;
   endtask

   // Drives one request through grant, AR, R and RESP acting as core and interconnect.
   task automatic txn(input vec_t v, output bit own_data, output logic [39:0] ar_addr,
                      output logic [31:0] word, output int lat, output bit good);
      int n;
      int c0;
      good = 1'b1; own_data = 1'b0; ar_addr = '0; word = '0; lat = -1;
      bus.Inst_Req_Valid = v.iv; bus.PC = v.pc; bus.MemRead = v.dv; bus.Address = v.ad;
      n = 0;
      @(negedge cpu_clk);
      while (!(bus.Inst_Req_Ready || bus.Mem_Req_Ready) && n < 20) begin
         @(negedge cpu_clk); n++;
      end
      if (n >= 20) begin good = 1'b0; clear_inputs(); return; end
      own_data = bus.Mem_Req_Ready;
      c0 = cyc;
      @(posedge cpu_clk); #1;
      if (own_data) bus.MemRead = 1'b0; else bus.Inst_Req_Valid = 1'b0;
      if (v.pend) begin
         if (own_data) bus.Inst_Req_Valid = 1'b1; else bus.MemRead = 1'b1;
      end
      n = 0;
      @(negedge cpu_clk);
      while (!bus.cpu_arvalid && n < 20) begin @(negedge cpu_clk); n++; end
      if (n >= 20) begin good = 1'b0; clear_inputs(); return; end
      ar_addr = bus.cpu_araddr;
      for (int i = 0; i < v.ar_dly; i++) begin
         if (!bus.cpu_arvalid || bus.cpu_araddr !== ar_addr || bus.cpu_rready || !busy_ok())
            good = 1'b0;
         @(negedge cpu_clk);
      end
      if (bus.cpu_rready || !bus.cpu_arvalid || bus.cpu_araddr !== ar_addr) good = 1'b0;
      bus.cpu_arready = 1'b1;
      @(posedge cpu_clk); #1;
      bus.cpu_arready = 1'b0;
      @(negedge cpu_clk);
      for (int i = 0; i < v.r_dly; i++) begin
         if (!bus.cpu_rready || bus.cpu_arvalid || !busy_ok()) good = 1'b0;
         @(negedge cpu_clk);
      end
      if (!bus.cpu_rready || bus.cpu_arvalid) good = 1'b0;
      bus.cpu_rvalid = 1'b1; bus.cpu_rlast = 1'b1; bus.cpu_rdata = v.rd;
      @(posedge cpu_clk); #1;
      bus.cpu_rvalid = 1'b0; bus.cpu_rlast = 1'b0; bus.cpu_rdata = '0;
      n = 0;
      @(negedge cpu_clk);
      while (!(bus.Inst_Valid || bus.Read_data_Valid) && n < 20) begin
         @(negedge cpu_clk); n++;
      end
      if (n >= 20) begin good = 1'b0; clear_inputs(); return; end
      lat = cyc - c0;
      word = own_data ? bus.Read_data : bus.Instruction;
      for (int i = 0; i <= v.stall; i++) begin
         if (own_data ? (!bus.Read_data_Valid || bus.Inst_Valid) : (!bus.Inst_Valid || bus.Read_data_Valid))
            good = 1'b0;
         if ((own_data ? bus.Read_data : bus.Instruction) !== word) good = 1'b0;
         if (bus.cpu_arvalid || bus.cpu_rready || !busy_ok()) good = 1'b0;
         if (i < v.stall) @(negedge cpu_clk);
      end
      if (own_data) bus.Read_data_Ready = 1'b1; else bus.Inst_Ready = 1'b1;
      @(posedge cpu_clk); #1;
      bus.Read_data_Ready = 1'b0; bus.Inst_Ready = 1'b0;
      bus.Inst_Req_Valid = 1'b0; bus.MemRead = 1'b0;
   endtask

   initial begin : main
      bit          od;
      logic [39:0] aa;
      logic [31:0] ww;
      int          lt;
      bit          ok;
      int          base;
      vec_t        tv;

      vecs[0] = '{1'b1, 32'h0000_1000, 1'b0, 32'h0, 1, 1, 32'h0000_0013, 0, 1'b0, 1'b0, 40'h00_0000_1000};
      vecs[1] = '{1'b0, 32'h0, 1'b1, 32'hDEAD_BEE0, 0, 0, 32'hCAFE_F00D, 2, 1'b0, 1'b1, 40'h00_DEAD_BEE0};
      vecs[2] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 0, 0, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 40'h00_FFFF_FFFC};
      vecs[3] = '{1'b0, 32'h0, 1'b1, 32'h0000_0000, 3, 2, 32'h0000_0000, 1, 1'b0, 1'b1, 40'h00_0000_0000};
      vecs[4] = '{1'b1, 32'h0000_2000, 1'b0, 32'h0000_9000, 0, 1, 32'h1234_5678, 5, 1'b1, 1'b0, 40'h00_0000_2000};
      vecs[5] = '{1'b1, 32'h0000_4000, 1'b0, 32'h0, 7, 0, 32'h0BAD_CAFE, 0, 1'b0, 1'b0, 40'h00_0000_4000};

      clear_inputs();
      cpu_resetn = 1'b0;
      bus.Inst_Req_Valid = 1'b1;
      bus.MemRead = 1'b1;
      repeat (2) @(negedge cpu_clk);
      check("rst_arvalid", bus.cpu_arvalid, 0);
      check("rst_rready", bus.cpu_rready, 0);
      check("rst_inst_valid", bus.Inst_Valid, 0);
      check("rst_rd_valid", bus.Read_data_Valid, 0);
      check("rst_inst_req_ready", bus.Inst_Req_Ready, 0);
      check("rst_mem_req_ready", bus.Mem_Req_Ready, 0);
      check("rst_araddr", bus.cpu_araddr, 0);
      clear_inputs();
      @(negedge cpu_clk);
      cpu_resetn = 1'b1;
      check("arsize", bus.cpu_arsize, 3'b010);
      check("arburst", bus.cpu_arburst, 2'b01);
      check("arlen", bus.cpu_arlen, 8'd0);

      // No requester: no AXI activity.
      base = ar_cnt;
      od = 1'b0;
      repeat (4) begin
         @(negedge cpu_clk);
         if (bus.cpu_arvalid || bus.cpu_rready) od = 1'b1;
      end
      check("idle_no_ar", od, 0);
      check("idle_ar_cnt", ar_cnt - base, 0);
      @(posedge cpu_clk); #1;

      for (int k = 0; k < 6; k++) begin
         txn(vecs[k], od, aa, ww, lt, ok);
         check($sformatf("v%0d_owner", k), od, vecs[k].exp_data);
         check($sformatf("v%0d_araddr", k), aa, vecs[k].exp_addr);
         check($sformatf("v%0d_data", k), ww, vecs[k].rd);
         check($sformatf("v%0d_latency", k), lt, 3 + vecs[k].ar_dly + vecs[k].r_dly);
         check($sformatf("v%0d_protocol", k), ok, 1);
      end

      // Tie right after reset: load first, then the fetch.
      do_reset();
      base = ar_cnt;
      tv = '{1'b1, 32'h0000_2000, 1'b1, 32'h0000_8000, 0, 0, 32'hAAAA_0001, 0, 1'b0, 1'b1, 40'h0};
      txn(tv, od, aa, ww, lt, ok);
      check("tie1_owner", od, 1);
      check("tie1_araddr", aa, 40'h00_0000_8000);
      check("tie1_protocol", ok, 1);
      tv = '{1'b1, 32'h0000_2000, 1'b0, 32'h0, 0, 0, 32'hAAAA_0002, 0, 1'b0, 1'b0, 40'h0};
      txn(tv, od, aa, ww, lt, ok);
      check("tie2_owner", od, 0);
      check("tie2_araddr", aa, 40'h00_0000_2000);
      check("tie2_data", ww, 32'hAAAA_0002);
      check("tie_ar_handshakes", ar_cnt - base, 2);

      // Four back-to-back ties.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         tv = '{1'b1, 32'h0000_6000 + 32'(k * 16), 1'b1, 32'h0000_7000 + 32'(k * 16),
                0, 0, 32'h5500_0000 + 32'(k), 0, 1'b0, 1'b0, 40'h0};
         txn(tv, od, aa, ww, lt, ok);
         check($sformatf("rr%0d_owner", k), od, RR ? ((k % 2) == 0) : 1'b1);
         check($sformatf("rr%0d_araddr", k), aa,
               {8'h0, (RR ? ((k % 2) == 0) : 1'b1) ? tv.ad : tv.pc});
         check($sformatf("rr%0d_protocol", k), ok, 1);
      end

      // Reset asserted while in R with a beat on the bus.
      do_reset();
      bus.PC = 32'h0000_5000;
      bus.Inst_Req_Valid = 1'b1;
      od = 1'b0;
      for (int n = 0; n < 20 && !od; n++) begin
         @(negedge cpu_clk);
         od = bus.Inst_Req_Ready;
      end
      check("mid_grant", od, 1);
      @(posedge cpu_clk); #1;
      bus.Inst_Req_Valid = 1'b0;
      @(negedge cpu_clk);
      check("mid_arvalid", bus.cpu_arvalid, 1);
      bus.cpu_arready = 1'b1;
      @(posedge cpu_clk); #1;
      bus.cpu_arready = 1'b0;
      @(negedge cpu_clk);
      check("mid_rready", bus.cpu_rready, 1);
      bus.cpu_rvalid = 1'b1; bus.cpu_rlast = 1'b1; bus.cpu_rdata = 32'hDEAD_DEAD;
      cpu_resetn = 1'b0;
      #1;
      check("mid_rst_arvalid", bus.cpu_arvalid, 0);
      check("mid_rst_rready", bus.cpu_rready, 0);
      check("mid_rst_inst_valid", bus.Inst_Valid, 0);
      check("mid_rst_rd_valid", bus.Read_data_Valid, 0);
      @(posedge cpu_clk); #1;
      check("mid_rst_discard", bus.Instruction, 0);
      clear_inputs();
      @(negedge cpu_clk);
      cpu_resetn = 1'b1;
      @(posedge cpu_clk); #1;
      tv = '{1'b1, 32'h0000_3000, 1'b0, 32'h0, 0, 0, 32'h0000_0033, 0, 1'b0, 1'b0, 40'h0};
      txn(tv, od, aa, ww, lt, ok);
      check("post_rst_owner", od, 0);
      check("post_rst_araddr", aa, 40'h00_0000_3000);
      check("post_rst_data", ww, 32'h0000_0033);
      check("post_rst_latency", lt, 3);
      check("post_rst_protocol", ok, 1);

      repeat (2) @(negedge cpu_clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
